// File: rtl/axi_ni_response_pinout_pack_if.sv
// ---------------------------------------------------------------------------
// axi_ni_response_pinout_pack_if
// Groups the signals around the target-side NI response pinout block:
//   - the AXI R and B response channels coming from the AXI slave, and
//   - the single-beat response stream going to the NI response packetizer.
//
// Handshake semantics (all channels): a beat transfers on a rising clock edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until that transfer. The ready signal may depend combinationally on
// valid.
//
// Modports:
//   master - the pinout block: drives RREADY/BREADY and the resp_* stream.
//   slave  - the environment: the AXI slave plus the packetizer.
//
// Parameters: AXIRDATAWD (read data width), BEATCNTWD (beat index width).
// Width macros default here when no NI include has defined them.
// ---------------------------------------------------------------------------
`ifndef AXIIDWD
`define AXIIDWD 4
`endif
`ifndef AXIRESPWD
`define AXIRESPWD 2
`endif
`ifndef PACKETTRANSIDWD
`define PACKETTRANSIDWD 6
`endif
`ifndef PACKETREADDATAWD
`define PACKETREADDATAWD 32
`endif
`ifndef PACKETRESPONSEWD
`define PACKETRESPONSEWD 2
`endif
`ifndef PACKETRESPDVA
`define PACKETRESPDVA 2'd1
`endif
`ifndef PACKETRESPERR
`define PACKETRESPERR 2'd2
`endif

interface axi_ni_response_pinout_pack_if #(
  parameter int AXIRDATAWD = 32,
  parameter int BEATCNTWD  = 8
);
  logic [`AXIIDWD-1:0]          RID;
  logic [AXIRDATAWD-1:0]        RDATA;
  logic [`AXIRESPWD-1:0]        RRESP;
  logic                         RLAST;
  logic                         RVALID;
  logic                         RREADY;
  logic [`AXIIDWD-1:0]          BID;
  logic [`AXIRESPWD-1:0]        BRESP;
  logic                         BVALID;
  logic                         BREADY;
  logic                         resp_valid;
  logic                         resp_ready;
  logic                         resp_is_read;
  logic [`PACKETTRANSIDWD-1:0]  resp_id;
  logic [`PACKETREADDATAWD-1:0] resp_data;
  logic [`PACKETRESPONSEWD-1:0] resp_code;
  logic                         resp_locked;
  logic                         resp_last;
  logic [BEATCNTWD-1:0]         resp_beat;

  modport master (
    input  RID, RDATA, RRESP, RLAST, RVALID, BID, BRESP, BVALID, resp_ready,
    output RREADY, BREADY, resp_valid, resp_is_read, resp_id, resp_data,
           resp_code, resp_locked, resp_last, resp_beat
  );

  modport slave (
    output RID, RDATA, RRESP, RLAST, RVALID, BID, BRESP, BVALID, resp_ready,
    input  RREADY, BREADY, resp_valid, resp_is_read, resp_id, resp_data,
           resp_code, resp_locked, resp_last, resp_beat
  );
endinterface

// File: rtl/axi_ni_response_pinout_pack.sv
// ---------------------------------------------------------------------------
// axi_ni_response_pinout_pack
// Target-side NI block facing an AXI slave. Accepts R and B responses,
// maps AXI response codes to packet response codes and presents one beat at
// a time to the response packetizer from a single registered holding stage.
// R and B are arbitrated; a read burst, once started, owns the output until
// its RLAST beat. Read beats are numbered within the burst.
//
// Ports:
//   clock        - rising-edge clock
//   reset_n      - asynchronous active-low reset
//   bus          - master modport of axi_ni_response_pinout_pack_if
//                  (R/B channels in, resp_* stream out)
//   dbg_state    - current FSM state (0 = IDLE, 1 = R_BURST)
//   dbg_beat_cnt - current read beat counter
//
// Build option: define NI_RESP_WRITE_PRIORITY_EN to make B always win over R
// in IDLE (no round-robin pointer). Default build uses round-robin.
// ---------------------------------------------------------------------------
`ifndef AXIIDWD
`define AXIIDWD 4
`endif
`ifndef AXIRESPWD
`define AXIRESPWD 2
`endif
`ifndef PACKETTRANSIDWD
`define PACKETTRANSIDWD 6
`endif
`ifndef PACKETREADDATAWD
`define PACKETREADDATAWD 32
`endif
`ifndef PACKETRESPONSEWD
`define PACKETRESPONSEWD 2
`endif
`ifndef PACKETRESPDVA
`define PACKETRESPDVA 2'd1
`endif
`ifndef PACKETRESPERR
`define PACKETRESPERR 2'd2
`endif

module axi_ni_response_pinout_pack #(
  parameter int FLIT_WIDTH = 32,
  parameter int AXIRDATAWD = 32,
  parameter int BEATCNTWD  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  axi_ni_response_pinout_pack_if.master bus,
  output logic                 dbg_state,
  output logic [BEATCNTWD-1:0] dbg_beat_cnt
);

  localparam int ID_W   = `PACKETTRANSIDWD;
  localparam int DATA_W = `PACKETREADDATAWD;
  localparam int CODE_W = `PACKETRESPONSEWD;
  localparam logic [`AXIRESPWD-1:0] AXI_EXOKAY = `AXIRESPWD'(1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_R_BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [BEATCNTWD-1:0] beat_q;
  logic                 load_ok;
  logic                 grant_r, grant_b;
  logic                 r_acc, b_acc;

`ifndef NI_RESP_WRITE_PRIORITY_EN
  // 0 favours R, 1 favours B when both channels are valid in IDLE.
  logic                 rr_favour_b_q;
`endif

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic [CODE_W-1:0] map_code(input logic [`AXIRESPWD-1:0] r);
    return r[1] ? `PACKETRESPERR : `PACKETRESPDVA;
  endfunction

  // Holding register can take a beat when empty or when it drains this cycle.
  // Gated by reset_n so the ready outputs are also 0 while reset is held.
  assign load_ok = reset_n & (~bus.resp_valid | bus.resp_ready);

  always_comb begin
    grant_r = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.RVALID && bus.BVALID) begin
`ifdef NI_RESP_WRITE_PRIORITY_EN
          grant_b = 1'b1;
`else
          grant_b = rr_favour_b_q;
          grant_r = ~rr_favour_b_q;
`endif
        end else begin
          grant_r = bus.RVALID;
          grant_b = bus.BVALID;
        end
      end
      ST_R_BURST: grant_r = bus.RVALID;
      default: begin
        grant_r = 1'b0;
        grant_b = 1'b0;
      end
    endcase
  end

  assign bus.RREADY = load_ok & grant_r;
  assign bus.BREADY = load_ok & grant_b;
  assign r_acc      = bus.RREADY & bus.RVALID;
  assign b_acc      = bus.BREADY & bus.BVALID;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (r_acc && !bus.RLAST) state_d = ST_R_BURST;
      ST_R_BURST: if (r_acc && bus.RLAST)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      beat_q           <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_is_read <= 1'b0;
      bus.resp_id      <= '0;
      bus.resp_data    <= '0;
      bus.resp_code    <= '0;
      bus.resp_locked  <= 1'b0;
      bus.resp_last    <= 1'b0;
      bus.resp_beat    <= '0;
    end else begin
      state_q <= state_d;
      if (r_acc) begin
        bus.resp_valid   <= 1'b1;
        bus.resp_is_read <= 1'b1;
        bus.resp_id      <= ID_W'(bus.RID);
        bus.resp_data    <= DATA_W'(bus.RDATA);
        bus.resp_code    <= map_code(bus.RRESP);
        bus.resp_locked  <= (bus.RRESP == AXI_EXOKAY);
        bus.resp_last    <= bus.RLAST;
        bus.resp_beat    <= beat_q;
        // Counter wraps silently past its maximum; RLAST restarts numbering.
        beat_q           <= bus.RLAST ? '0 : beat_q + BEATCNTWD'(1);
      end else if (b_acc) begin
        bus.resp_valid   <= 1'b1;
        bus.resp_is_read <= 1'b0;
        bus.resp_id      <= ID_W'(bus.BID);
        bus.resp_data    <= '0;
        bus.resp_code    <= map_code(bus.BRESP);
        bus.resp_locked  <= (bus.BRESP == AXI_EXOKAY);
        bus.resp_last    <= 1'b1;
        bus.resp_beat    <= '0;
      end else if (bus.resp_ready) begin
        bus.resp_valid   <= 1'b0;
      end
    end
  end

`ifndef NI_RESP_WRITE_PRIORITY_EN
  // Pointer moves after every B and after every completed read burst.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_favour_b_q <= 1'b0;
    end else if (b_acc || (r_acc && bus.RLAST)) begin
      rr_favour_b_q <= ~rr_favour_b_q;
    end
  end
`endif

  assign dbg_state    = state_q;
  assign dbg_beat_cnt = beat_q;

endmodule

// File: tb/tb_axi_ni_response_pinout_pack.sv
`ifndef AXIIDWD
`define AXIIDWD 4
`endif
`ifndef AXIRESPWD
`define AXIRESPWD 2
`endif
`ifndef PACKETTRANSIDWD
`define PACKETTRANSIDWD 6
`endif
`ifndef PACKETREADDATAWD
`define PACKETREADDATAWD 32
`endif
`ifndef PACKETRESPONSEWD
`define PACKETRESPONSEWD 2
`endif
`ifndef PACKETRESPDVA
`define PACKETRESPDVA 2'd1
`endif
`ifndef PACKETRESPERR
`define PACKETRESPERR 2'd2
`endif

module tb_axi_ni_response_pinout_pack;
  localparam int AXIW = `AXIIDWD;
  localparam int IDW  = `PACKETTRANSIDWD;
  localparam int DW   = `PACKETREADDATAWD;
  localparam int CW   = `PACKETRESPONSEWD;
  localparam int RW   = `AXIRESPWD;
  localparam logic [CW-1:0] DVA = `PACKETRESPDVA;
  localparam logic [CW-1:0] ERR = `PACKETRESPERR;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  logic dbg_state;
  logic [7:0] dbg_beat_cnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  axi_ni_response_pinout_pack_if #(.AXIRDATAWD(32), .BEATCNTWD(8)) bus ();

  axi_ni_response_pinout_pack #(.FLIT_WIDTH(32), .AXIRDATAWD(32), .BEATCNTWD(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_beat_cnt (dbg_beat_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic          is_read;
    logic [IDW-1:0] id;
    logic [DW-1:0] data;
    logic [CW-1:0] code;
    logic          locked;
    logic          last;
    logic [7:0]    beat;
  } beat_t;

  beat_t exp_q[$];       // beats accepted but not yet consumed, oldest first
  bit    in_burst;       // a read burst has started and not seen RLAST
  bit    favour_r;       // which channel wins a tie in IDLE
  logic [7:0] beat_n;    // index the next read beat will carry
  bit    last_er, last_eb;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] code_of(input logic [RW-1:0] r);
    return (r >= RW'(2)) ? ERR : DVA;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    in_burst = 0;
    favour_r = 1;
    beat_n   = 8'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 0; bus.RVALID = 0;
    bus.BID = '0; bus.BRESP = '0; bus.BVALID = 0; bus.resp_ready = 0;
  endtask

  task automatic apply_reset();
    reset_n = 0;
    drive_idle();
    repeat (2) @(negedge clock);
    model_reset();
    reset_n = 1;
  endtask

  // One clock: inputs were set after a negedge. Predict which channel is
  // accepted from the arbitration rules, update the expected stream at the
  // edge, then compare the output stage at the following negedge.
  task automatic step();
    bit load_ok, er, eb;
    beat_t b;
    #1;
    load_ok = (exp_q.size() == 0) || (bus.resp_ready === 1'b1);
    er = 0; eb = 0;
    if (in_burst) begin
      er = load_ok && bus.RVALID;
    end else if (bus.RVALID && bus.BVALID) begin
`ifdef NI_RESP_WRITE_PRIORITY_EN
      eb = load_ok;
`else
      if (favour_r) er = load_ok; else eb = load_ok;
`endif
    end else begin
      er = load_ok && bus.RVALID;
      eb = load_ok && bus.BVALID;
    end
    chk("rready", bus.RREADY, er);
    chk("bready", bus.BREADY, eb);
    last_er = er;
    last_eb = eb;
    @(posedge clock);
    if (exp_q.size() > 0 && bus.resp_ready) void'(exp_q.pop_front());
    if (er) begin
      b.is_read = 1; b.id = IDW'(bus.RID); b.data = DW'(bus.RDATA);
      b.code = code_of(bus.RRESP); b.locked = (bus.RRESP == RW'(1));
      b.last = bus.RLAST; b.beat = beat_n;
      exp_q.push_back(b);
      if (bus.RLAST) begin
        beat_n = 8'd0; in_burst = 0; favour_r = !favour_r;
      end else begin
        beat_n = beat_n + 8'd1; in_burst = 1;
      end
    end
    if (eb) begin
      b.is_read = 0; b.id = IDW'(bus.BID); b.data = '0;
      b.code = code_of(bus.BRESP); b.locked = (bus.BRESP == RW'(1));
      b.last = 1; b.beat = 8'd0;
      exp_q.push_back(b);
      favour_r = !favour_r;
    end
    @(negedge clock);
    chk("resp_valid", bus.resp_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("resp_is_read", bus.resp_is_read, exp_q[0].is_read);
      chk("resp_id",      bus.resp_id,      exp_q[0].id);
      chk("resp_data",    bus.resp_data,    exp_q[0].data);
      chk("resp_code",    bus.resp_code,    exp_q[0].code);
      chk("resp_locked",  bus.resp_locked,  exp_q[0].locked);
      chk("resp_last",    bus.resp_last,    exp_q[0].last);
      chk("resp_beat",    bus.resp_beat,    exp_q[0].beat);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    bit r_pend, b_pend;
    int r_left;
    logic [AXIW-1:0] r_id;

    reset_n = 0;
    drive_idle();
    model_reset();
    apply_reset();

    // reset state
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_is_read", bus.resp_is_read, 0);
    chk("rst_id", bus.resp_id, 0);
    chk("rst_data", bus.resp_data, 0);
    chk("rst_code", bus.resp_code, 0);
    chk("rst_last", bus.resp_last, 0);
    chk("rst_beat", bus.resp_beat, 0);
    chk("rst_locked", bus.resp_locked, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_cnt", dbg_beat_cnt, 0);

    // single B
    bus.resp_ready = 1; bus.BVALID = 1; bus.BID = AXIW'(3); bus.BRESP = RW'(0);
    step();
    bus.BVALID = 0;
    chk("b1_valid", bus.resp_valid, 1);
    chk("b1_is_read", bus.resp_is_read, 0);
    chk("b1_id", bus.resp_id, 3);
    chk("b1_code", bus.resp_code, DVA);
    chk("b1_last", bus.resp_last, 1);
    chk("b1_data", bus.resp_data, 0);
    step();

    // 4-beat R burst with B pending throughout
    apply_reset();
    bus.resp_ready = 1; bus.BVALID = 1; bus.BID = AXIW'(7); bus.BRESP = RW'(0);
    for (int i = 0; i < 4; i++) begin
      bus.RVALID = 1; bus.RID = AXIW'(5); bus.RDATA = 32'h10 + 32'(i);
      bus.RRESP = RW'(0); bus.RLAST = (i == 3);
      step();
      chk("burst_beat", bus.resp_beat, i);
      chk("burst_data", bus.resp_data, 32'h10 + 32'(i));
      chk("burst_last", bus.resp_last, (i == 3));
      chk("burst_is_read", bus.resp_is_read, 1);
    end
    bus.RVALID = 0; bus.RLAST = 0;
    step();
    bus.BVALID = 0;
    chk("after_burst_b", bus.resp_is_read, 0);
    chk("after_burst_bid", bus.resp_id, 7);
    step();

    // both valid from reset, single-beat R and single B
    apply_reset();
    bus.resp_ready = 1; bus.RVALID = 1; bus.RLAST = 1; bus.RID = AXIW'(1);
    bus.BVALID = 1; bus.BID = AXIW'(2);
    for (int k = 0; k < 4; k++) begin
      bus.RDATA = 32'(k);
      step();
`ifdef NI_RESP_WRITE_PRIORITY_EN
      chk("arb_order", bus.resp_is_read, 0);
`else
      chk("arb_order", bus.resp_is_read, (k % 2) == 0);
`endif
    end
    bus.RVALID = 0; bus.BVALID = 0; bus.RLAST = 0;
    step();

    // EXOKAY on R, DECERR on B
    bus.RVALID = 1; bus.RRESP = RW'(1); bus.RLAST = 1; bus.RDATA = 32'h55;
    step();
    bus.RVALID = 0; bus.RLAST = 0; bus.RRESP = '0;
    chk("exokay_code", bus.resp_code, DVA);
    chk("exokay_locked", bus.resp_locked, 1);
    bus.BVALID = 1; bus.BRESP = RW'(3); bus.BID = AXIW'(9);
    step();
    bus.BVALID = 0; bus.BRESP = '0;
    chk("decerr_code", bus.resp_code, ERR);
    chk("decerr_locked", bus.resp_locked, 0);
    step();

    // backpressure: hold resp_ready low 3 cycles, then stream
    bus.resp_ready = 1; bus.RVALID = 1; bus.RLAST = 0; bus.RID = AXIW'(4); bus.RDATA = 32'hA0;
    step();
    bus.resp_ready = 0; bus.RDATA = 32'hA1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_data", bus.resp_data, 32'hA0);
      chk("bp_hold_valid", bus.resp_valid, 1);
    end
    bus.resp_ready = 1;
    for (int j = 1; j < 4; j++) begin
      bus.RDATA = 32'hA0 + 32'(j); bus.RLAST = (j == 3);
      step();
      chk("bp_stream_data", bus.resp_data, 32'hA0 + 32'(j));
      chk("bp_stream_beat", bus.resp_beat, j);
    end
    bus.RVALID = 0; bus.RLAST = 0;
    step();

    // reset during beat 2 of a burst
    bus.resp_ready = 1; bus.RVALID = 1; bus.RLAST = 0; bus.RID = AXIW'(6);
    for (int j = 0; j < 2; j++) begin
      bus.RDATA = 32'h20 + 32'(j);
      step();
    end
    bus.RDATA = 32'h22;
    #2 reset_n = 0;
    #1;
    chk("mid_rst_valid", bus.resp_valid, 0);
    chk("mid_rst_data", bus.resp_data, 0);
    chk("mid_rst_beat", bus.resp_beat, 0);
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_cnt", dbg_beat_cnt, 0);
    chk("mid_rst_rready", bus.RREADY, 0);
    model_reset();
    bus.RVALID = 0;
    @(negedge clock);
    reset_n = 1;
    bus.RVALID = 1; bus.RDATA = 32'h30; bus.RLAST = 0;
    step();
    chk("post_rst_beat0", bus.resp_beat, 0);
    bus.RDATA = 32'h31; bus.RLAST = 1;
    step();
    chk("post_rst_beat1", bus.resp_beat, 1);
    bus.RVALID = 0; bus.RLAST = 0;
    step();

    // counter wrap in an over-long burst
    bus.resp_ready = 1; bus.RVALID = 1;
    for (int i = 0; i < 258; i++) begin
      bus.RDATA = 32'(i); bus.RLAST = (i == 257);
      step();
      if (i == 255) chk("wrap_255", bus.resp_beat, 255);
      if (i == 256) chk("wrap_0", bus.resp_beat, 0);
    end
    bus.RVALID = 0; bus.RLAST = 0;
    step();

    // random traffic
    r_pend = 0; b_pend = 0; r_left = 0; r_id = '0;
    for (int c = 0; c < 800; c++) begin
      if (!r_pend && $urandom_range(0, 2) == 0) begin
        if (r_left == 0) begin
          r_left = $urandom_range(1, 5);
          r_id   = AXIW'($urandom);
        end
        r_pend = 1;
        bus.RID = r_id; bus.RDATA = $urandom; bus.RRESP = RW'($urandom_range(0, 3));
        bus.RLAST = (r_left == 1);
      end
      if (!b_pend && $urandom_range(0, 3) == 0) begin
        b_pend = 1;
        bus.BID = AXIW'($urandom); bus.BRESP = RW'($urandom_range(0, 3));
      end
      bus.RVALID = r_pend;
      bus.BVALID = b_pend;
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_er) begin r_pend = 0; r_left--; end
      if (last_eb) b_pend = 0;
    end
    bus.RVALID = 0; bus.BVALID = 0; bus.resp_ready = 1;
    repeat (3) step();
    chk("drain_empty", bus.resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
